bsg_wormhole_stream_gen: RTL and testbench
==========================================

Name: bsg_wormhole_stream_gen

Overview:
- Transmit-side counterpart of the wormhole stream-control logic. It takes one packet header plus a data-flit count on a header channel, and a data-flit stream on a data channel.
- It emits one bsg_wormhole packet on a single link: hdr_len_p header flits (cord, len, protocol header, LSB first), then the data flits unmodified.
- It sits between BedRock burst senders and the wormhole router injection port. No data is buffered; data flits pass straight through.

Parameters:
- flit_width_p, 64, width of one link flit.
- cord_width_p, 8, router coordinate width.
- len_width_p, 4, wormhole len field width.
- pr_hdr_width_p, 100, protocol header width.
- hdr_len_p, 2, number of header flits. Must satisfy hdr_len_p*flit_width_p >= cord_width_p+len_width_p+pr_hdr_width_p, and hdr_len_p >= 1.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- hdr_cord_i  in  cord_width_p  destination coordinate
- hdr_pr_i  in  pr_hdr_width_p  protocol header
- hdr_data_cnt_i  in  len_width_p  number of data flits (0 allowed)
- hdr_v_i  in  1  header valid
- hdr_ready_and_o  out  1  header accepted when hdr_v_i & hdr_ready_and_o
- data_i  in  flit_width_p  data flit
- data_v_i  in  1  data valid
- data_ready_and_o  out  1  data ready
- link_data_o  out  flit_width_p  flit to router
- link_v_o  out  1  flit valid
- link_ready_and_i  in  1  router ready

Behaviour:
- Header packing into a hdr_len_p*flit_width_p register, LSB first: {zero pad, pr, len, cord}.
  - len = hdr_len_p + hdr_data_cnt_i - 1, computed in len_width_p bits.
  - Overflow is illegal; a simulation assertion flags hdr_len_p + cnt - 1 > 2^len_width_p - 1.
- States: e_idle, e_hdr, e_data.
- Reset (reset_n_i low, asynchronous) → e_idle, counters 0, hdr register 0.
  - Reset outputs: link_v_o=0, data_ready_and_o=0, hdr_ready_and_o=1 once out of reset (it is 0 while reset_n_i is low).
  - Reset mid-packet discards the packet; no partial-packet recovery.
- hdr_ready_and_o = (state==e_idle) | last_out, where last_out is the link handshake on the packet's final flit.
  - This gives back-to-back packets with no bubble.
- Header accept:
  - Latches the packed header.
  - Loads the header flit counter with hdr_len_p and the data counter with hdr_data_cnt_i.
  - Next state e_hdr.
  - Latency: header accepted in cycle N → first header flit valid in cycle N+1.
- e_hdr:
  - link_v_o=1; link_data_o = current flit slice (flit index = hdr_len_p - hdr counter).
  - Each link handshake decrements the hdr counter.
  - On the handshake with hdr counter==1: if data counter != 0 → e_data; else the packet is done → e_hdr if a new header is accepted in the same cycle, otherwise e_idle.
- e_data:
  - link_v_o = data_v_i; data_ready_and_o = link_ready_and_i; link_data_o = data_i (combinational pass-through).
  - Each handshake decrements the data counter.
  - On the handshake with data counter==1: packet done; next state as above.
- In e_idle and e_hdr: data_ready_and_o=0, and data_i is ignored.
- link_v_o never depends on link_ready_and_i (valid-then-ready compliant).
- Header and data flits must not change while link_v_o & ~link_ready_and_i; the header register guarantees this for header flits.

Decomposition:
- Shared package bsg_wormhole_stream_pkg:
  - state enum (e_idle, e_hdr, e_data);
  - packed wormhole header struct {len, cord} generator macro;
  - len computation function shared with the receive-side stream control.
- Sub-module: reuse bsg_counter_set_down for both flit counters, with set_and_down_exclusive_p=0.
- A piso-style header slice mux is inline; no separate module is needed.

Test Plan:
- Reset: hold reset_n_i low across a clock edge, then release → link_v_o=0, data_ready_and_o=0, hdr_ready_and_o=1.
- Single packet, hdr_len_p=2, cnt=3, link always ready → header accepted cycle 0; flits in cycles 1–5 = hdr0, hdr1, d0, d1, d2; len field = 4.
- cnt=0 → exactly 2 header flits with len=1; data_ready_and_o stays 0; data_v_i=1 is ignored.
- Back-to-back: second header held valid throughout → accepted on the last-flit handshake; its hdr0 follows with no idle cycle.
- Backpressure: link_ready_and_i toggles 1010… and data_v_i drops mid-packet → flits are held stable while stalled; count, order and len are correct; data_ready_and_o follows link_ready_and_i in e_data.
- Async reset asserted mid-data (cnt=5, after 2 data flits) → link_v_o drops immediately without waiting for a clock edge; after release, a new packet goes out cleanly.

Source files
------------

// File: rtl/bsg_wormhole_stream_pkg.sv
// Shared definitions for the wormhole stream generator and its receive-side peer:
// FSM states, the {len, cord} header struct generator and the len arithmetic.

`ifndef BSG_WORMHOLE_STREAM_PKG_SV
`define BSG_WORMHOLE_STREAM_PKG_SV

// Expands to a packed wormhole routing header with cord in the low bits.
`define BSG_WORMHOLE_STREAM_HDR_STRUCT(struct_name, cord_w, len_w) \
   typedef struct packed {                                          \
      logic [len_w-1:0]  len;                                       \
      logic [cord_w-1:0] cord;                                      \
   } struct_name;

package bsg_wormhole_stream_pkg;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_hdr  = 2'd1,
      e_data = 2'd2
   } stream_state_e;

   // The wormhole len field counts every flit after the first one.
   function automatic int unsigned wormhole_len(input int unsigned hdr_len,
                                                input int unsigned data_cnt);
      return hdr_len + data_cnt - 1;
   endfunction

   function automatic bit wormhole_len_fits(input int unsigned hdr_len,
                                            input int unsigned data_cnt,
                                            input int unsigned len_w);
      longint unsigned total;
      longint unsigned limit;
      total = longint'(hdr_len) + longint'(data_cnt) - 1;
      limit = (64'd1 << len_w) - 1;
      return total <= limit;
   endfunction

endpackage

`endif

// File: rtl/bsg_counter_set_down.sv
// Loadable down counter. When set and down coincide and the two are not declared
// exclusive, the decrement applies to the freshly loaded value.

module bsg_counter_set_down #(
   parameter int width_p                  = 4,
   parameter bit set_and_down_exclusive_p = 1'b0
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               set_i,
   input  logic [width_p-1:0] val_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_r_o
);

   logic [width_p-1:0] ctr_q;
   logic [width_p-1:0] ctr_d;
   logic [width_p-1:0] dec;

   always_comb begin
      dec = '0;
      dec[0] = down_i;
      if (set_and_down_exclusive_p) begin
         ctr_d = set_i ? val_i : (ctr_q - dec);
      end else begin
         ctr_d = (set_i ? val_i : ctr_q) - dec;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ctr_q <= '0;
      end else begin
         ctr_q <= ctr_d;
      end
   end

   assign count_r_o = ctr_q;

endmodule

// File: rtl/bsg_wormhole_stream_gen.sv
// Transmit-side wormhole packetiser: one header plus a data-flit count becomes
// hdr_len_p header flits followed by the data flits passed straight through.

module bsg_wormhole_stream_gen
   import bsg_wormhole_stream_pkg::*;
#(
   parameter int flit_width_p   = 64,
   parameter int cord_width_p   = 8,
   parameter int len_width_p    = 4,
   parameter int pr_hdr_width_p = 100,
   parameter int hdr_len_p      = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,

   input  logic [cord_width_p-1:0]   hdr_cord_i,
   input  logic [pr_hdr_width_p-1:0] hdr_pr_i,
   input  logic [len_width_p-1:0]    hdr_data_cnt_i,
   input  logic                      hdr_v_i,
   output logic                      hdr_ready_and_o,

   input  logic [flit_width_p-1:0]   data_i,
   input  logic                      data_v_i,
   output logic                      data_ready_and_o,

   output logic [flit_width_p-1:0]   link_data_o,
   output logic                      link_v_o,
   input  logic                      link_ready_and_i
);

   localparam int hdr_w     = hdr_len_p * flit_width_p;
   localparam int content_w = cord_width_p + len_width_p + pr_hdr_width_p;
   localparam int hdr_cnt_w = $clog2(hdr_len_p + 1);

   `BSG_WORMHOLE_STREAM_HDR_STRUCT(wh_hdr_s, cord_width_p, len_width_p)

   stream_state_e state_q, state_d;
   logic [hdr_w-1:0] hdr_q, hdr_d;

   logic [hdr_cnt_w-1:0]    hdr_cnt;
   logic [len_width_p-1:0]  data_cnt;

   wh_hdr_s                 wh_hdr;
   logic [hdr_w-1:0]        packed_hdr;
   logic [flit_width_p-1:0] hdr_flit;

   logic link_v;
   logic link_hs;
   logic hdr_last;
   logic data_last;
   logic last_out;
   logic hdr_ready;
   logic hdr_accept;
   logic hdr_down;
   logic data_down;

   always_comb begin
      wh_hdr.cord = hdr_cord_i;
      wh_hdr.len  = len_width_p'(wormhole_len(32'(hdr_len_p), 32'(hdr_data_cnt_i)));
      packed_hdr  = '0;
      packed_hdr[content_w-1:0] = {hdr_pr_i, wh_hdr};
   end

   // The counter runs hdr_len_p..1, so flit i is presented when it equals hdr_len_p-i.
   always_comb begin
      hdr_flit = '0;
      for (int i = 0; i < hdr_len_p; i++) begin
         if (hdr_cnt == hdr_cnt_w'(hdr_len_p - i)) begin
            hdr_flit = hdr_q[i*flit_width_p +: flit_width_p];
         end
      end
   end

   // Valid never looks at ready; ready on the data side is the link's ready.
   always_comb begin
      link_v     = (state_q == e_hdr) | ((state_q == e_data) & data_v_i);
      link_hs    = link_v & link_ready_and_i;
      hdr_last   = (state_q == e_hdr) & (hdr_cnt == hdr_cnt_w'(1)) & (data_cnt == '0);
      data_last  = (state_q == e_data) & (data_cnt == len_width_p'(1));
      last_out   = link_hs & (hdr_last | data_last);
      hdr_ready  = reset_n_i & ((state_q == e_idle) | last_out);
      hdr_accept = hdr_v_i & hdr_ready;
      hdr_down   = link_hs & (state_q == e_hdr) & ~hdr_accept;
      data_down  = link_hs & (state_q == e_data) & ~hdr_accept;
   end

   always_comb begin
      hdr_d = hdr_accept ? packed_hdr : hdr_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         e_idle: begin
            if (hdr_accept) begin
               state_d = e_hdr;
            end
         end
         e_hdr: begin
            if (link_hs && (hdr_cnt == hdr_cnt_w'(1))) begin
               if (data_cnt != '0) begin
                  state_d = e_data;
               end else begin
                  state_d = hdr_accept ? e_hdr : e_idle;
               end
            end
         end
         e_data: begin
            if (link_hs && (data_cnt == len_width_p'(1))) begin
               state_d = hdr_accept ? e_hdr : e_idle;
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_idle;
         hdr_q   <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
      end
   end

   bsg_counter_set_down #(
      .width_p                  (hdr_cnt_w),
      .set_and_down_exclusive_p (1'b0)
   ) hdr_counter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .set_i     (hdr_accept),
      .val_i     (hdr_cnt_w'(hdr_len_p)),
      .down_i    (hdr_down),
      .count_r_o (hdr_cnt)
   );

   bsg_counter_set_down #(
      .width_p                  (len_width_p),
      .set_and_down_exclusive_p (1'b0)
   ) data_counter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .set_i     (hdr_accept),
      .val_i     (hdr_data_cnt_i),
      .down_i    (data_down),
      .count_r_o (data_cnt)
   );

   assign hdr_ready_and_o  = hdr_ready;
   assign data_ready_and_o = (state_q == e_data) & link_ready_and_i;
   assign link_v_o         = link_v;
   assign link_data_o      = (state_q == e_data) ? data_i : hdr_flit;

   // A len that wraps would mis-route the tail of the worm.
   len_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      hdr_accept |-> wormhole_len_fits(32'(hdr_len_p), 32'(hdr_data_cnt_i), 32'(len_width_p)));

endmodule

// File: tb/tb_bsg_wormhole_stream_gen.sv
// Bench for bsg_wormhole_stream_gen: directed scenarios plus randomized traffic,
// checked against a flit-list model of each packet.

module tb_bsg_wormhole_stream_gen;

   localparam int FW = 64;
   localparam int CW = 8;
   localparam int LW = 4;
   localparam int PW = 100;
   localparam int HL = 2;

   logic          clk;
   logic          reset_n_i;
   logic [CW-1:0] hdr_cord_i;
   logic [PW-1:0] hdr_pr_i;
   logic [LW-1:0] hdr_data_cnt_i;
   logic          hdr_v_i;
   logic          hdr_ready_and_o;
   logic [FW-1:0] data_i;
   logic          data_v_i;
   logic          data_ready_and_o;
   logic [FW-1:0] link_data_o;
   logic          link_v_o;
   logic          link_ready_and_i;

   bsg_wormhole_stream_gen #(
      .flit_width_p   (FW),
      .cord_width_p   (CW),
      .len_width_p    (LW),
      .pr_hdr_width_p (PW),
      .hdr_len_p      (HL)
   ) dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n_i),
      .hdr_cord_i       (hdr_cord_i),
      .hdr_pr_i         (hdr_pr_i),
      .hdr_data_cnt_i   (hdr_data_cnt_i),
      .hdr_v_i          (hdr_v_i),
      .hdr_ready_and_o  (hdr_ready_and_o),
      .data_i           (data_i),
      .data_v_i         (data_v_i),
      .data_ready_and_o (data_ready_and_o),
      .link_data_o      (link_data_o),
      .link_v_o         (link_v_o),
      .link_ready_and_i (link_ready_and_i)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // model state: expected link flits (with a data/header tag) and the data source
   logic [FW-1:0] exp_q[$];
   bit            exp_isd_q[$];
   logic [FW-1:0] data_src_q[$];

   bit            hdr_pend   = 1'b0;
   bit            stall_hold = 1'b0;
   logic [CW-1:0] p_cord;
   logic [PW-1:0] p_pr;
   logic [LW-1:0] p_cnt;
   logic [FW-1:0] p_data[$];

   int acc_cyc       = 0;
   int last_flit_cyc = 0;
   int data_popped   = 0;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // driver: present a new header with cnt random data flits
   task automatic prep_hdr(input int cnt);
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      p_cord = CW'($urandom_range(0, 255));
      p_pr   = r[PW-1:0];
      p_cnt  = LW'(cnt);
      p_data.delete();
      for (int i = 0; i < cnt; i++) p_data.push_back(rand64());
      hdr_cord_i     = p_cord;
      hdr_pr_i       = p_pr;
      hdr_data_cnt_i = p_cnt;
      hdr_pend       = 1'b1;
   endtask

   // reference: the packet as a flat flit list
   task automatic model_accept();
      logic [127:0] h;
      logic [LW-1:0] len;
      int l;
      l   = HL + int'(p_cnt) - 1;
      len = l[LW-1:0];
      h   = {16'h0, p_pr, len, p_cord};
      exp_q.push_back(h[63:0]);    exp_isd_q.push_back(1'b0);
      exp_q.push_back(h[127:64]);  exp_isd_q.push_back(1'b0);
      foreach (p_data[i]) begin
         exp_q.push_back(p_data[i]);
         exp_isd_q.push_back(1'b1);
         data_src_q.push_back(p_data[i]);
      end
      hdr_pend = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic model_check();
      bit isd, ev, er, lastf;
      isd   = (exp_q.size() > 0) && exp_isd_q[0];
      ev    = (exp_q.size() > 0) && (!isd || data_v_i);
      lastf = ev && link_ready_and_i && (exp_q.size() == 1);
      er    = (exp_q.size() == 0) || lastf;
      chk("link_v", FW'(link_v_o), FW'(ev));
      chk("data_ready", FW'(data_ready_and_o), FW'(isd && link_ready_and_i));
      chk("hdr_ready", FW'(hdr_ready_and_o), FW'(er));
      if (ev) chk("link_data", link_data_o, exp_q[0]);
      stall_hold = isd && ev && !link_ready_and_i;
      if (ev && link_ready_and_i) begin
         if (isd) begin
            void'(data_src_q.pop_front());
            data_popped++;
         end
         void'(exp_q.pop_front());
         void'(exp_isd_q.pop_front());
         last_flit_cyc = cyc;
      end
      if (hdr_pend && er) model_accept();
   endtask

   task automatic cycle(input bit rdy, input bit dv);
      link_ready_and_i = rdy;
      data_v_i         = dv | stall_hold;
      hdr_v_i          = hdr_pend;
      data_i           = (data_src_q.size() > 0) ? data_src_q[0] : '0;
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // mode 0: always ready/valid; 1: ready toggles 1010 with random data gaps; 2: random
   task automatic step(input int mode);
      bit rdy, dv;
      case (mode)
         0: begin rdy = 1'b1; dv = 1'b1; end
         1: begin rdy = (cyc % 2 == 0); dv = ($urandom_range(0, 3) != 0); end
         default: begin rdy = ($urandom_range(0, 3) != 0); dv = ($urandom_range(0, 3) != 0); end
      endcase
      cycle(rdy, dv);
   endtask

   task automatic drain(input int mode, input int max);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || hdr_pend) && n < max) begin
         step(mode);
         n++;
      end
      chk("drain_done", FW'(exp_q.size() + int'(hdr_pend)), '0);
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_isd_q.delete();
      data_src_q.delete();
      hdr_pend   = 1'b0;
      stall_hold = 1'b0;
   endtask

   int a_cyc;
   int base;
   int n;

   initial begin
      reset_n_i        = 1'b0;
      hdr_cord_i       = '0;
      hdr_pr_i         = '0;
      hdr_data_cnt_i   = '0;
      hdr_v_i          = 1'b0;
      data_i           = '0;
      data_v_i         = 1'b0;
      link_ready_and_i = 1'b0;

      // reset held across clock edges
      @(posedge clk); @(posedge clk); #1;
      chk("rst_link_v", FW'(link_v_o), '0);
      chk("rst_hdr_ready_low", FW'(hdr_ready_and_o), '0);
      chk("rst_data_ready", FW'(data_ready_and_o), '0);
      #2 reset_n_i = 1'b1;
      #1;
      chk("post_rst_hdr_ready", FW'(hdr_ready_and_o), FW'(1));
      chk("post_rst_link_v", FW'(link_v_o), '0);
      chk("post_rst_data_ready", FW'(data_ready_and_o), '0);
      @(posedge clk); #1;

      // single packet, cnt=3, link always ready
      prep_hdr(3);
      drain(0, 40);
      chk("single_latency", FW'(last_flit_cyc - acc_cyc), FW'(5));

      // cnt=0 with data_v_i held high
      prep_hdr(0);
      drain(0, 40);
      chk("zero_cnt_latency", FW'(last_flit_cyc - acc_cyc), FW'(2));

      // back-to-back: second header valid as soon as the first is taken
      prep_hdr(2);
      cycle(1'b1, 1'b1);
      a_cyc = acc_cyc;
      prep_hdr(0);
      drain(0, 40);
      chk("b2b_span", FW'(last_flit_cyc - a_cyc), FW'(6));

      // backpressure with toggling ready and data gaps
      prep_hdr(4);  drain(1, 200);
      prep_hdr(1);  drain(1, 200);
      prep_hdr(7);  drain(1, 200);

      // async reset in the middle of the data phase
      prep_hdr(5);
      base = data_popped;
      n = 0;
      while (data_popped < base + 2 && n < 50) begin
         cycle(1'b1, 1'b1);
         n++;
      end
      chk("pre_reset_data_flits", FW'(data_popped - base), FW'(2));
      chk("pre_reset_link_v", FW'(link_v_o), FW'(1));
      #2 reset_n_i = 1'b0;
      #1;
      chk("async_rst_link_v", FW'(link_v_o), '0);
      chk("async_rst_data_ready", FW'(data_ready_and_o), '0);
      chk("async_rst_hdr_ready", FW'(hdr_ready_and_o), '0);
      model_clear();
      @(posedge clk); #1;
      chk("rst_hold_link_v", FW'(link_v_o), '0);
      #2 reset_n_i = 1'b1;
      #1;
      chk("rst_release_hdr_ready", FW'(hdr_ready_and_o), FW'(1));
      @(posedge clk); #1;
      prep_hdr(3);
      drain(2, 200);

      // randomized traffic, mostly back-to-back
      for (int i = 0; i < 30; i++) begin
         int m;
         m = (i < 15) ? 2 : 1;
         prep_hdr($urandom_range(0, 14));
         n = 0;
         while (hdr_pend && n < 200) begin
            step(m);
            n++;
         end
         chk("rand_hdr_taken", FW'(hdr_pend), '0);
         if ($urandom_range(0, 3) == 0) drain(m, 400);
      end
      drain(2, 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
